// File: rtl/div_unit.sv
// Multi-cycle 32-bit signed/unsigned restoring divider for DIV/DIVU.
// result_o = {remainder, quotient}; ready_o holds while start_i stays high.
module div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_BYZERO = 2'd1;
  localparam logic [1:0] ST_ON     = 2'd2;
  localparam logic [1:0] ST_END    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        signed_q, signed_d;
  logic        neg1_q, neg1_d;
  logic        neg2_q, neg2_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] op1_abs, op2_abs;
  logic [32:0] diff;
  logic [31:0] quot_fix, rem_fix;

  // Working register layout: [64:33] partial remainder, [31:0] quotient/dividend bits.
  always_comb begin
    op1_abs  = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    op2_abs  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    diff     = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
    quot_fix = (signed_q && (neg1_q ^ neg2_q)) ? (~work_q[31:0] + 32'd1) : work_q[31:0];
    rem_fix  = (signed_q && neg1_q) ? (~work_q[64:33] + 32'd1) : work_q[64:33];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    signed_d  = signed_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      ST_FREE: begin
        ready_d = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_d = ST_BYZERO;
          end else begin
            work_d    = {32'd0, op1_abs, 1'b0};
            divisor_d = op2_abs;
            signed_d  = signed_div_i;
            neg1_d    = opdata1_i[31];
            neg2_d    = opdata2_i[31];
            cnt_d     = 6'd0;
            state_d   = ST_ON;
          end
        end
      end
      ST_BYZERO: begin
        if (annul_i) begin
          state_d = ST_FREE;
        end else begin
          result_d = 64'd0;
          ready_d  = 1'b1;
          state_d  = ST_END;
        end
      end
      ST_ON: begin
        if (annul_i) begin
          state_d = ST_FREE;
        end else if (cnt_q != 6'd32) begin
          // Negative difference means the divisor did not fit: quotient bit 0.
          if (diff[32]) work_d = {work_q[63:0], 1'b0};
          else          work_d = {diff[31:0], work_q[31:0], 1'b1};
          cnt_d = cnt_q + 6'd1;
        end else begin
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
          state_d  = ST_END;
        end
      end
      ST_END: begin
        if (!start_i) begin
          ready_d = 1'b0;
          state_d = ST_FREE;
        end
      end
      default: state_d = ST_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FREE;
      cnt_q     <= 6'd0;
      work_q    <= 65'd0;
      divisor_q <= 32'd0;
      signed_q  <= 1'b0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit signed/unsigned integer divider used by the EX stage for DIV/DIVU. It is the requesting end of the pipeline stall protocol: while a division is in flight, EX holds `start_i` and raises `stallreq_from_ex`. The stall controller then freezes PC/IF/ID/EX with stall pattern 6'b001111 until `ready_o` returns. The result is written to HI/LO through the normal EX→MEM path.

## Interface
- No parameters; width fixed at 32 (operands) / 64 (result).
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `signed_div_i` input 1: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with operands.
- `opdata1_i` input 32: dividend.
- `opdata2_i` input 32: divisor.
- `start_i` input 1: division request, held high by EX until it sees `ready_o`.
- `annul_i` input 1: cancel in-flight division (pipeline flush).
- `result_o` output 64: {remainder[31:0], quotient[31:0]}.
- `ready_o` output 1: result valid.

## Operation
- Reset (`rst_n`=0, asynchronous):
  - state = FREE, `ready_o` = 0, `result_o` = 0, counter = 0.
- FREE:
  - `ready_o` = 0.
  - If `start_i`=1 and `annul_i`=0:
    - If `opdata2_i`=0, go to BYZERO.
    - Otherwise latch the operands, converting to absolute value when `signed_div_i`=1 and bit 31 = 1. Also latch `signed_div_i` and both operand sign bits. Clear the counter and go to ON.
  - Otherwise stay in FREE.
- BYZERO:
  - If `annul_i`, go to FREE.
  - Otherwise go to END with quotient = 0, remainder = 0.
- ON:
  - If `annul_i`, go to FREE; the partial result is discarded and `ready_o` stays 0.
  - If counter < 32, perform one restoring shift-subtract step and increment the counter:
    - 65-bit working register; compute a 33-bit difference = upper 32 bits − divisor.
    - If the difference is negative, shift left and insert quotient bit 0.
    - Otherwise replace the upper half with the difference, shift left and insert 1.
    - Quotient bits are produced MSB first.
  - If counter = 32, apply sign correction and go to END:
    - Signed with operand signs differing: quotient = two's-complement negate.
    - Signed with negative dividend: remainder = negate (remainder takes the dividend's sign).
- END:
  - `result_o` = final value, `ready_o` = 1, held for as long as `start_i`=1.
  - When `start_i`=0, go to FREE with `ready_o` = 0. `result_o` holds its last value until the next division ends.
- Operands are sampled only on the FREE→ON/BYZERO edge; input changes while busy are ignored.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
- Required EX-side handshake, stated here so both ends agree:
  - `start_i` = is_div & ~`ready_o`.
  - `stallreq_from_ex` = is_div & ~`ready_o`.
  - EX consumes `result_o` in the cycle `ready_o`=1. `start_i` falls in that cycle, so END→FREE on the next edge, and a back-to-back DIV starts cleanly from FREE.

## Timing
- E0 is the rising edge at which FREE samples `start_i`=1.
- Normal division:
  - E0: enter ON, counter = 0.
  - E0+1 … E0+32: the 32 steps.
  - E0+33: enter END; `ready_o` = 1 after E0+33.
  - Total busy = 33 cycles after E0.
- Divide by zero: BYZERO after E0, END with `ready_o` = 1 after E0+1.
- `annul_i` has priority over stepping and completion in ON/BYZERO and over starting in FREE. It does nothing in END; EX is flushed anyway and drops `start_i`.
- Asynchronous reset mid-operation returns all outputs to reset values immediately; no partial result survives.
- `ready_o` and `result_o` are registered; no combinational path from inputs to outputs.

## Test plan
- Unsigned 7 / 2, `start_i` held → `ready_o` rises after E0+33; `result_o` = {0x00000001, 0x00000003}. Drop `start_i` → FREE, `ready_o` = 0 the next cycle.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Same operands unsigned → quotient 0x7FFFFFFC, remainder 0x00000001.
- Divide by zero: 0x12345678 / 0 → `ready_o` after E0+1, `result_o` = 0.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- `annul_i` pulsed at E0+10 → FREE, `ready_o` never rises. A following start with 100 / 7 completes normally: quotient 14, remainder 2, ready after its own E0+33.
- `rst_n` low at E0+15 → outputs 0 immediately. Release and back-to-back DIVs using the EX handshake (start low for exactly one cycle between them) → both results correct, no lost or duplicated `ready_o`.
